// File: rtl/chronologic_if.sv
// Signal bundle between the alternation checker and its user.
// The master drives the control/data inputs; the slave returns the check results.
interface chronologic_if #(
  parameter int CNT_W = 16
);
  logic             en;
  logic             clr;
  logic             din;
  logic             pass;
  logic             fail;
  logic             err;
  logic             phase;
  logic [CNT_W-1:0] run_len;
  logic [CNT_W-1:0] pass_cnt;
  logic [CNT_W-1:0] fail_cnt;

  modport master (
    output en, clr, din,
    input  pass, fail, err, phase, run_len, pass_cnt, fail_cnt
  );

  modport slave (
    input  en, clr, din,
    output pass, fail, err, phase, run_len, pass_cnt, fail_cnt
  );
endinterface

// File: rtl/chronologic.sv
// Alternation checker: din must toggle on every edge; reports pass/fail pulses and statistics.
// Define CHRONOLOGIC_COUNTERS_EN to build the saturating pass/fail event counters.
module chronologic #(
  parameter int CNT_W = 16
) (
  input  logic         clk,
  input  logic         rst,
  chronologic_if.slave bus
);

  logic             r_prev;
  logic             r_valid;
  logic             r_pass;
  logic             r_fail;
  logic             r_err;
  logic             r_phase;
  logic [CNT_W-1:0] r_run_len;

  logic             w_check;
  logic             w_ok;
  logic             w_fail;
  logic             w_err_nxt;
  logic             w_phase_nxt;
  logic [CNT_W-1:0] w_run_base;
  logic [CNT_W-1:0] w_run_nxt;

  assign w_check = r_valid & bus.en;
  assign w_ok    = bus.din ^ r_prev;
  assign w_fail  = w_check & ~w_ok;

  // Clear is applied first, then the check result overrides it.
  // NOTE: always_comb assigns every output a default first so no latch is inferred.
  always_comb begin
    w_err_nxt   = bus.clr ? 1'b0 : r_err;
    w_run_base  = bus.clr ? '0 : r_run_len;
    w_run_nxt   = w_run_base;
    w_phase_nxt = r_phase;
    if (!r_valid) begin
      w_phase_nxt = bus.din;
    end
    if (w_check && w_ok) begin
      w_run_nxt = (w_run_base == '1) ? w_run_base : w_run_base + 1'b1;
    end else if (w_fail) begin
      w_err_nxt   = 1'b1;
      w_run_nxt   = '0;
      w_phase_nxt = bus.din;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev    <= 1'b0;
      r_valid   <= 1'b0;
      r_pass    <= 1'b0;
      r_fail    <= 1'b0;
      r_err     <= 1'b0;
      r_phase   <= 1'b0;
      r_run_len <= '0;
    end else begin
      r_prev    <= bus.din;
      r_valid   <= 1'b1;
      r_pass    <= w_check & w_ok;
      r_fail    <= w_fail;
      r_err     <= w_err_nxt;
      r_phase   <= w_phase_nxt;
      r_run_len <= w_run_nxt;
    end
  end

`ifdef CHRONOLOGIC_COUNTERS_EN
  logic [CNT_W-1:0] r_pass_cnt;
  logic [CNT_W-1:0] r_fail_cnt;
  logic [CNT_W-1:0] w_pass_base;
  logic [CNT_W-1:0] w_fail_base;

  assign w_pass_base = bus.clr ? '0 : r_pass_cnt;
  assign w_fail_base = bus.clr ? '0 : r_fail_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pass_cnt <= '0;
      r_fail_cnt <= '0;
    end else begin
      r_pass_cnt <= w_pass_base;
      r_fail_cnt <= w_fail_base;
      if (w_check && w_ok && (w_pass_base != '1)) begin
        r_pass_cnt <= w_pass_base + 1'b1;
      end
      if (w_fail && (w_fail_base != '1)) begin
        r_fail_cnt <= w_fail_base + 1'b1;
      end
    end
  end

  assign bus.pass_cnt = r_pass_cnt;
  assign bus.fail_cnt = r_fail_cnt;
`else
  assign bus.pass_cnt = '0;
  assign bus.fail_cnt = '0;
`endif

  assign bus.pass    = r_pass;
  assign bus.fail    = r_fail;
  assign bus.err     = r_err;
  assign bus.phase   = r_phase;
  assign bus.run_len = r_run_len;

endmodule

// File: tb/tb_chronologic.sv
// Directed and randomized bench for chronologic, checked against a rule-level model.
module tb_chronologic;
  localparam int CNT_W = 4;
  localparam int MAXV  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  chronologic_if #(.CNT_W(CNT_W)) bus ();

  chronologic #(.CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference state, updated once per edge from the behavioural rules.
  int m_prev, m_valid, m_pass, m_fail, m_err, m_phase, m_run, m_pc, m_fc;

  function automatic int sat_inc(input int v);
    return (v >= MAXV) ? MAXV : v + 1;
  endfunction

  function automatic int exp_cnt(input int v);
`ifdef CHRONOLOGIC_COUNTERS_EN
    return v;
`else
    return 0;
`endif
  endfunction

  task automatic model_reset();
    m_prev = 0; m_valid = 0; m_pass = 0; m_fail = 0; m_err = 0;
    m_phase = 0; m_run = 0; m_pc = 0; m_fc = 0;
  endtask

  task automatic model_edge(input int e, input int c, input int d);
    int chk;
    int ok;
    chk = (m_valid != 0) && (e != 0);
    ok  = (d != m_prev);
    if (c != 0) begin
      m_err = 0; m_run = 0; m_pc = 0; m_fc = 0;
    end
    m_pass = chk && ok;
    m_fail = chk && !ok;
    if (m_pass != 0) begin
      m_run = sat_inc(m_run);
      m_pc  = sat_inc(m_pc);
    end
    if (m_fail != 0) begin
      m_err   = 1;
      m_run   = 0;
      m_fc    = sat_inc(m_fc);
      m_phase = d;
    end
    if (m_valid == 0) m_phase = d;
    m_prev  = d;
    m_valid = 1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".pass"},     32'(bus.pass),     32'(m_pass));
    check({tag, ".fail"},     32'(bus.fail),     32'(m_fail));
    check({tag, ".err"},      32'(bus.err),      32'(m_err));
    check({tag, ".phase"},    32'(bus.phase),    32'(m_phase));
    check({tag, ".run_len"},  32'(bus.run_len),  32'(m_run));
    check({tag, ".pass_cnt"}, 32'(bus.pass_cnt), 32'(exp_cnt(m_pc)));
    check({tag, ".fail_cnt"}, 32'(bus.fail_cnt), 32'(exp_cnt(m_fc)));
  endtask

  // Inputs change 1 time unit after the edge; outputs are sampled at the same point.
  task automatic step(input string tag, input logic e, input logic c, input logic d);
    bus.en  = e;
    bus.clr = c;
    bus.din = d;
    @(posedge clk);
    model_edge(int'(e), int'(c), int'(d));
    #1;
    compare_all(tag);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".pass"},     32'(bus.pass),     32'd0);
    check({tag, ".fail"},     32'(bus.fail),     32'd0);
    check({tag, ".err"},      32'(bus.err),      32'd0);
    check({tag, ".phase"},    32'(bus.phase),    32'd0);
    check({tag, ".run_len"},  32'(bus.run_len),  32'd0);
    check({tag, ".pass_cnt"}, 32'(bus.pass_cnt), 32'd0);
    check({tag, ".fail_cnt"}, 32'(bus.fail_cnt), 32'd0);
  endtask

  initial begin
    logic cur;
    bus.en = 1'b0; bus.clr = 1'b0; bus.din = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;

    // Clean alternation from reset: first edge only loads history.
    step("s1_e1", 1, 0, 0);
    check("s1_e1_nopulse", 32'(bus.pass | bus.fail), 32'd0);
    step("s1_e2", 1, 0, 1);
    step("s1_e3", 1, 0, 0);
    step("s1_e4", 1, 0, 1);
    step("s1_e5", 1, 0, 0);
    step("s1_e6", 1, 0, 1);
    check("s1_run_len", 32'(bus.run_len), 32'd5);
    check("s1_phase",   32'(bus.phase),   32'd0);
    check("s1_err",     32'(bus.err),     32'd0);

    // Toggles then a repeated 0 forces a resync.
    step("s2_a", 1, 0, 0);
    step("s2_b", 1, 0, 1);
    step("s2_c", 1, 0, 0);
    step("s2_rep", 1, 0, 0);
    check("s2_fail",     32'(bus.fail),     32'd1);
    check("s2_err",      32'(bus.err),      32'd1);
    check("s2_run_len",  32'(bus.run_len),  32'd0);
    check("s2_phase",    32'(bus.phase),    32'd0);
    check("s2_fail_cnt", 32'(bus.fail_cnt), 32'(exp_cnt(1)));

    // Alternation after resync; err remains until cleared.
    step("s3_a", 1, 0, 1);
    step("s3_b", 1, 0, 0);
    step("s3_c", 1, 0, 1);
    step("s3_d", 1, 0, 0);
    step("s3_e", 1, 0, 1);
    check("s3_run_len", 32'(bus.run_len), 32'd5);
    check("s3_err",     32'(bus.err),     32'd1);
    step("s3_clr", 0, 1, 0);
    check("s3_clr_err",  32'(bus.err),      32'd0);
    check("s3_clr_pcnt", 32'(bus.pass_cnt), 32'd0);
    check("s3_clr_fcnt", 32'(bus.fail_cnt), 32'd0);
    check("s3_clr_run",  32'(bus.run_len),  32'd0);

    // Disabled checking while din holds; resume with a toggle.
    step("s4_d1", 0, 0, 0);
    step("s4_d2", 0, 0, 0);
    step("s4_d3", 0, 0, 0);
    check("s4_nofail", 32'(bus.fail), 32'd0);
    step("s4_resume", 1, 0, 1);
    check("s4_pass", 32'(bus.pass), 32'd1);

    // Clear coincident with a repeat: clear then record the failure.
    step("s5_clr_rep", 1, 1, 1);
    check("s5_err",      32'(bus.err),      32'd1);
    check("s5_fail_cnt", 32'(bus.fail_cnt), 32'(exp_cnt(1)));

    // Saturation of run_len and pass_cnt.
    cur = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cur = ~cur;
      step("s6_sat", 1, 0, cur);
    end
    check("s6_run_sat",  32'(bus.run_len),  32'(MAXV));
    check("s6_pcnt_sat", 32'(bus.pass_cnt), 32'(exp_cnt(MAXV)));

    // Reset between edges takes effect immediately and drops history.
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check_all_zero("s7_rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    step("s7_first", 1, 0, ~cur);
    check("s7_nopulse", 32'(bus.pass | bus.fail), 32'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      logic e, c, d;
      e   = ($urandom_range(0, 9) != 0);
      c   = ($urandom_range(0, 29) == 0);
      d   = ($urandom_range(0, 7) == 0) ? cur : ~cur;
      cur = d;
      step("rand", e, c, d);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
